tt_eval: RTL and testbench

TT_EVAL -- requirements
Module: tt_eval

---
 rtl/tt_eval.sv | 99 +++++++++
 tb/tb_tt_eval.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_eval.sv
// tt_eval: evaluates a serially loadable truth table against a captured operand.
// An operand is accepted with a valid/ready handshake. Its result appears after a
// fixed settle delay and is held until the consumer takes it.
module tt_eval #(
  parameter int                    N_IN          = 4,
  parameter logic [(2**N_IN)-1:0]  TT_INIT       = 16'hC248,
  parameter int                    SETTLE_CYCLES = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic            out,
  input  logic            out_ready,
  input  logic            cfg_we,
  input  logic            cfg_bit,
  output logic            cfg_ready
);

  localparam int         W      = 2**N_IN;
  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t          state;
  state_t          next_state;
  logic [W-1:0]    tt;
  logic [W-1:0]    tt_next;
  logic [N_IN-1:0] index;
  logic [7:0]      count;
  logic            take;

  // An operand can be accepted when idle, or when a held result is being consumed
  // in the same cycle.
  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign cfg_ready = (state == IDLE);
  assign take      = in_valid && in_ready;

  // The table after this cycle's shift. An operand accepted in the same cycle
  // sees the shifted table.
  always_comb begin
    tt_next = tt;
    if (cfg_we && cfg_ready) tt_next = {tt[W-2:0], cfg_bit};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. With a zero settle delay, accepting an operand leads straight to HOLD.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (take) next_state = (SETTLE_CYCLES > 0) ? EVAL : HOLD;
      EVAL: if (count <= 8'd1) next_state = HOLD;
      HOLD: if (out_ready) begin
              if (in_valid) next_state = (SETTLE_CYCLES > 0) ? EVAL : HOLD;
              else          next_state = IDLE;
            end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: truth table, captured index, settle counter and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt        <= TT_INIT;
      index     <= '0;
      count     <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      tt <= tt_next;
      if (take) begin
        index <= in_data;
        count <= SETTLE;
        if (SETTLE_CYCLES == 0) begin
          out       <= tt_next[in_data];
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (state == EVAL) begin
        count <= count - 8'd1;
        if (count <= 8'd1) begin
          out       <= tt[index];
          out_valid <= 1'b1;
        end
      end else if ((state == HOLD) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tt_eval.sv
// tb_tt_eval: directed and randomized checks of tt_eval against a truth-table model.
module tb_tt_eval;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out, out_ready;
  logic       cfg_we, cfg_bit, cfg_ready;
  logic [3:0] in_data;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out, b_out_ready;
  logic       b_cfg_we, b_cfg_bit, b_cfg_ready;
  logic [1:0] b_in_data;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] tt_m;

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  tt_eval dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out(out), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_bit(cfg_bit), .cfg_ready(cfg_ready)
  );

  tt_eval #(.N_IN(2), .TT_INIT(4'b1000), .SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out(b_out), .out_ready(b_out_ready),
    .cfg_we(b_cfg_we), .cfg_bit(b_cfg_bit), .cfg_ready(b_cfg_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
      else begin
        fails++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Shift one configuration bit in while idle. The model treats the table as a
  // number that doubles and gains the new bit.
  task automatic apply_stimulus(input logic b);
    cfg_we  = 1'b1;
    cfg_bit = b;
    step();
    cfg_we  = 1'b0;
    tt_m    = 16'((32'(tt_m) * 2 + 32'(b)) % 65536);
  endtask

  // Wait until out_valid is seen, giving up after a bounded number of cycles.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  // One complete operation from idle. The operand may be accepted together with
  // a config bit. The result may be stalled before it is consumed.
  task automatic do_op(input logic [3:0] d, input int stall, input bit with_cfg, input logic cb);
    int   n;
    logic exp_out;
    in_valid  = 1'b1;
    in_data   = d;
    cfg_we    = with_cfg;
    cfg_bit   = cb;
    out_ready = (stall == 0);
    check_output("in_ready_idle", in_ready, 1);
    step();
    if (with_cfg) tt_m = 16'((32'(tt_m) * 2 + 32'(cb)) % 65536);
    exp_out  = tt_m[d];
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    in_data  = 4'($urandom);
    wait_valid(n);
    check_output("latency", n, 3);
    check_output("result", out, exp_out);
    for (int i = 0; i < stall; i++) begin
      step();
      check_output("stall_valid", out_valid, 1);
      check_output("stall_out", out, exp_out);
    end
    out_ready = 1'b1;
    step();
    check_output("consumed", out_valid, 0);
  endtask

  initial begin
    int   n;
    bit   seen;
    logic exp_out;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cfg_we = 1'b0; cfg_bit = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1; b_cfg_we = 1'b0; b_cfg_bit = 1'b0;
    tt_m = 16'hC248;

    // Behaviour while reset is held and right after it is released
    #12;
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out", out, 0);
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_cfg_ready", cfg_ready, 1);
    step();
    rst_n = 1'b1;
    check_output("post_rst_in_ready", in_ready, 1);
    check_output("post_rst_cfg_ready", cfg_ready, 1);

    // Default table, single operand
    do_op(4'h3, 0, 1'b0, 1'b0);

    // Two operands back-to-back
    in_valid = 1'b1; in_data = 4'h0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    wait_valid(n);
    check_output("b2b_lat0", n, 3);
    check_output("b2b_res0", out, tt_m[0]);
    in_valid = 1'b1; in_data = 4'hF;
    check_output("b2b_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check_output("b2b_gap", out_valid, 0);
    wait_valid(n);
    check_output("b2b_lat1", n, 3);
    check_output("b2b_res1", out, tt_m[15]);
    step();
    check_output("b2b_idle", out_valid, 0);

    // Full serial reload with 0x0001, most significant bit first
    for (int i = 15; i >= 0; i--) apply_stimulus(logic'(i == 0));
    check_output("reload_model", tt_m, 16'h0001);
    do_op(4'h0, 0, 1'b0, 1'b0);
    do_op(4'h3, 0, 1'b0, 1'b0);

    // Long stall in HOLD. Config pulses and operand changes must not act.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 4'h0;
    step();
    in_valid = 1'b0;
    exp_out  = tt_m[0];
    wait_valid(n);
    check_output("stall_lat", n, 3);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 4'($urandom); cfg_we = 1'b1; cfg_bit = 1'($urandom);
      step();
      check_output("hold_valid", out_valid, 1);
      check_output("hold_out", out, exp_out);
      check_output("hold_in_ready", in_ready, 0);
      check_output("hold_cfg_ready", cfg_ready, 0);
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    step();
    check_output("hold_release", out_valid, 0);
    for (int i = 0; i < 4; i++) do_op(4'(i * 5), 0, 1'b0, 1'b0);

    // Randomized partial loads, concurrent config-and-accept, and stalls
    for (int it = 0; it < 24; it++) begin
      int nbits;
      nbits = $urandom_range(0, 3);
      for (int k = 0; k < nbits; k++) apply_stimulus(1'($urandom));
      do_op(4'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end

    // Reset in the middle of an evaluation after reconfiguring the table
    for (int i = 0; i < 16; i++) apply_stimulus(1'($urandom));
    in_valid = 1'b1; in_data = 4'h3;
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_out_valid", out_valid, 0);
    check_output("midrst_in_ready", in_ready, 1);
    check_output("midrst_cfg_ready", cfg_ready, 1);
    tt_m = 16'hC248;
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    check_output("no_stale_result", seen, 0);
    do_op(4'h3, 0, 1'b0, 1'b0);

    // Zero-settle, two-input instance
    b_in_valid = 1'b1; b_in_data = 2'b11;
    check_output("b_in_ready", b_in_ready, 1);
    step();
    check_output("b_valid", b_out_valid, 1);
    check_output("b_out", b_out, 1);
    b_in_data = 2'b01;
    step();
    check_output("b_b2b_valid", b_out_valid, 1);
    check_output("b_b2b_out", b_out, 0);
    b_in_valid = 1'b0;
    step();
    check_output("b_idle", b_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
